// File: rtl/time_entry.sv
// time_entry: digit-by-digit 24-hour time entry controller.
//
// The operator keys six BCD digits (H1 H0 M1 M0 S1 S0). Each digit is
// confirmed with an enter press, checked against 24-hour limits and
// echoed on bcd. Once S0 is accepted the binary time is presented with
// a one-cycle load strobe, which presets the clock core's counters.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high
//   enter_n   in   raw push-button, active-low; a press accepts digit
//   cancel_n  in   raw push-button, active-low; a press aborts the entry
//   digit     in   [3:0] BCD digit candidate (static switches)
//   hour      out  [4:0] binary hour 0..23, holds last loaded value
//   minute    out  [5:0] binary minute 0..59
//   second    out  [5:0] binary second 0..59
//   load      out  one-cycle pulse, hour/minute/second are new
//   busy      out  high while an entry is in progress
//   pos       out  [2:0] index of next expected digit, 0=H1 .. 5=S0
//   bcd       out  [23:0] echo {H1,H0,M1,M0,S1,S0}, unentered slots 4'hF
//   err       out  one-cycle pulse, a digit was rejected
//   abort     out  one-cycle pulse, entry abandoned by cancel or timeout
module time_entry #(
  parameter int unsigned TIMEOUT = 250_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enter_n,
  input  logic        cancel_n,
  input  logic [3:0]  digit,
  output logic [4:0]  hour,
  output logic [5:0]  minute,
  output logic [5:0]  second,
  output logic        load,
  output logic        busy,
  output logic [2:0]  pos,
  output logic [23:0] bcd,
  output logic        err,
  output logic        abort
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_D0,
    ST_D1,
    ST_D2,
    ST_D3,
    ST_D4,
    ST_D5,
    ST_COMMIT
  } state_t;

  localparam logic [27:0] TO_LAST = 28'(TIMEOUT - 1);

  // Key conditioning: two synchronizer flops plus one edge-detect flop.
  logic enter_s1_q, enter_s2_q, enter_dly_q;
  logic cancel_s1_q, cancel_s2_q, cancel_dly_q;
  logic enter_press, cancel_press;

  state_t      state_q;
  state_t      state_d;
  logic [27:0] to_q;
  logic [23:0] bcd_q;
  logic [23:0] bcd_d;
  logic [4:0]  hour_q;
  logic [5:0]  minute_q, second_q;
  logic        load_q, busy_q, err_q, abort_q;
  logic [2:0]  pos_q;

  logic [2:0]  cur_idx;
  logic        dig_ok;
  logic        in_timed;
  logic        timed_out;

  function automatic logic digit_valid(input logic [2:0] idx,
                                       input logic [3:0] d,
                                       input logic [3:0] h1);
    logic ok;
    case (idx)
      3'd0:       ok = (d <= 4'd2);
      3'd1:       ok = (h1 == 4'd2) ? (d <= 4'd3) : (d <= 4'd9);
      3'd2, 3'd4: ok = (d <= 4'd5);
      default:    ok = (d <= 4'd9);
    endcase
    return ok;
  endfunction

  function automatic logic [6:0] bcd2bin(input logic [3:0] tens,
                                         input logic [3:0] ones);
    // tens*10 = tens*8 + tens*2
    return ({3'b000, tens} << 3) + ({3'b000, tens} << 1) + {3'b000, ones};
  endfunction

  assign enter_press  = enter_dly_q  & ~enter_s2_q;
  assign cancel_press = cancel_dly_q & ~cancel_s2_q;

  always_comb begin
    cur_idx = 3'd0;
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin cur_idx = 3'd0; state_d = ST_D1;     end
      ST_D0:   begin cur_idx = 3'd0; state_d = ST_D1;     end
      ST_D1:   begin cur_idx = 3'd1; state_d = ST_D2;     end
      ST_D2:   begin cur_idx = 3'd2; state_d = ST_D3;     end
      ST_D3:   begin cur_idx = 3'd3; state_d = ST_D4;     end
      ST_D4:   begin cur_idx = 3'd4; state_d = ST_D5;     end
      ST_D5:   begin cur_idx = 3'd5; state_d = ST_COMMIT; end
      default: begin cur_idx = 3'd0; state_d = ST_IDLE;   end
    endcase
  end

  // Echo with the candidate digit inserted; a fresh H1 starts from blank.
  always_comb begin
    bcd_d = (state_q == ST_IDLE) ? '1 : bcd_q;
    case (cur_idx)
      3'd0:    bcd_d[23:20] = digit;
      3'd1:    bcd_d[19:16] = digit;
      3'd2:    bcd_d[15:12] = digit;
      3'd3:    bcd_d[11:8]  = digit;
      3'd4:    bcd_d[7:4]   = digit;
      3'd5:    bcd_d[3:0]   = digit;
      default: ;
    endcase
  end

  assign dig_ok    = digit_valid(cur_idx, digit, bcd_q[23:20]);
  assign in_timed  = (state_q inside {ST_D1, ST_D2, ST_D3, ST_D4, ST_D5});
  assign timed_out = in_timed && (to_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      enter_s1_q   <= 1'b1;
      enter_s2_q   <= 1'b1;
      enter_dly_q  <= 1'b1;
      cancel_s1_q  <= 1'b1;
      cancel_s2_q  <= 1'b1;
      cancel_dly_q <= 1'b1;
      state_q      <= ST_IDLE;
      to_q         <= '0;
      bcd_q        <= '1;
      hour_q       <= '0;
      minute_q     <= '0;
      second_q     <= '0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      abort_q      <= 1'b0;
      pos_q        <= '0;
    end else begin
      enter_s1_q   <= enter_n;
      enter_s2_q   <= enter_s1_q;
      enter_dly_q  <= enter_s2_q;
      cancel_s1_q  <= cancel_n;
      cancel_s2_q  <= cancel_s1_q;
      cancel_dly_q <= cancel_s2_q;

      load_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          // Cancel has no effect here but still discards a coincident digit.
          to_q <= '0;
          if (enter_press && !cancel_press) begin
            if (dig_ok) begin
              bcd_q   <= bcd_d;
              state_q <= ST_D1;
              pos_q   <= 3'd1;
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        ST_COMMIT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          pos_q   <= '0;
          to_q    <= '0;
        end

        default: begin
          // An enter press in the same cycle as the last timeout count wins
          // over the timeout, since the press itself restarts the counter.
          if (cancel_press || (timed_out && !enter_press)) begin
            abort_q <= 1'b1;
            state_q <= ST_IDLE;
            bcd_q   <= '1;
            busy_q  <= 1'b0;
            pos_q   <= '0;
            to_q    <= '0;
          end else if (enter_press) begin
            to_q <= '0;
            if (dig_ok) begin
              bcd_q   <= bcd_d;
              state_q <= state_d;
              if (state_q == ST_D5) begin
                // Loaded values are registered on entry so they line up
                // with load in the COMMIT cycle.
                load_q   <= 1'b1;
                hour_q   <= 5'(bcd2bin(bcd_d[23:20], bcd_d[19:16]));
                minute_q <= 6'(bcd2bin(bcd_d[15:12], bcd_d[11:8]));
                second_q <= 6'(bcd2bin(bcd_d[7:4],   bcd_d[3:0]));
                pos_q    <= '0;
              end else begin
                pos_q <= cur_idx + 3'd1;
              end
            end else begin
              err_q <= 1'b1;
            end
          end else if (in_timed) begin
            to_q <= to_q + 28'd1;
          end
        end
      endcase
    end
  end

  assign hour   = hour_q;
  assign minute = minute_q;
  assign second = second_q;
  assign load   = load_q;
  assign busy   = busy_q;
  assign pos    = pos_q;
  assign bcd    = bcd_q;
  assign err    = err_q;
  assign abort  = abort_q;

endmodule

// File: tb/tb_time_entry.sv
// tb_time_entry: self-checking bench for time_entry (TIMEOUT overridden to 16).
// A vector table drives enter/cancel presses and checks the per-press
// response; loaded times go through a scoreboard queue popped on load.
module tb_time_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic        enter_n;
  logic        cancel_n;
  logic [3:0]  digit;
  logic [4:0]  hour;
  logic [5:0]  minute;
  logic [5:0]  second;
  logic        load;
  logic        busy;
  logic [2:0]  pos;
  logic [23:0] bcd;
  logic        err;
  logic        abort;

  always #5 clk = ~clk;

  time_entry #(.TIMEOUT(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .enter_n  (enter_n),
    .cancel_n (cancel_n),
    .digit    (digit),
    .hour     (hour),
    .minute   (minute),
    .second   (second),
    .load     (load),
    .busy     (busy),
    .pos      (pos),
    .bcd      (bcd),
    .err      (err),
    .abort    (abort)
  );

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } exp_t;

  // k: 1 = enter press, 2 = cancel press, 3 = both together.
  // hook: 0 = none, 1 = timeout wait afterwards, 2 = reset afterwards.
  typedef struct {
    logic [1:0]  k;
    logic [3:0]  d;
    logic        e_err;
    logic        e_abort;
    logic [2:0]  e_pos;
    logic [23:0] e_bcd;
    logic        e_load;
    logic [4:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
    int          hook;
  } vec_t;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned err_cnt = 0;
  int unsigned abort_cnt = 0;
  exp_t        sb[$];
  logic [4:0]  m_h = '0;
  logic [5:0]  m_m = '0;
  logic [5:0]  m_s = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] k, input logic [3:0] d,
                              input logic e_err, input logic e_abort,
                              input logic [2:0] e_pos, input logic [23:0] e_bcd,
                              input logic e_load, input logic [4:0] h,
                              input logic [5:0] m, input logic [5:0] s,
                              input int hook);
    vec_t v;
    v.k = k; v.d = d; v.e_err = e_err; v.e_abort = e_abort;
    v.e_pos = e_pos; v.e_bcd = e_bcd; v.e_load = e_load;
    v.h = h; v.m = m; v.s = s; v.hook = hook;
    return v;
  endfunction

  // Scoreboard consumer and pulse counters.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (load === 1'b1) begin
        chk("load_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("load_hour",   32'(hour),   32'(e.h));
          chk("load_minute", 32'(minute), 32'(e.m));
          chk("load_second", 32'(second), 32'(e.s));
        end
      end
      if (err === 1'b1)   err_cnt++;
      if (abort === 1'b1) abort_cnt++;
    end
  end

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    digit = v.d;
    if (v.k[0]) enter_n = 1'b0;
    if (v.k[1]) cancel_n = 1'b0;
    if (v.e_load) begin
      e.h = v.h; e.m = v.m; e.s = v.s;
      sb.push_back(e);
      m_h = v.h; m_m = v.m; m_s = v.s;
    end
    // two synchronizer stages plus the edge-detect edge consume the press
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("err",    32'(err),    32'(v.e_err));
    chk("abort",  32'(abort),  32'(v.e_abort));
    chk("pos",    32'(pos),    32'(v.e_pos));
    chk("bcd",    32'(bcd),    32'(v.e_bcd));
    chk("busy",   32'(busy),   32'(v.e_load | (v.e_pos != 3'd0)));
    chk("load",   32'(load),   32'(v.e_load));
    chk("hour",   32'(hour),   32'(m_h));
    chk("minute", 32'(minute), 32'(m_m));
    chk("second", 32'(second), 32'(m_s));
    enter_n  = 1'b1;
    cancel_n = 1'b1;
    @(negedge clk);
    if (v.e_load) begin
      chk("busy_after_load", 32'(busy), 32'd0);
      chk("load_one_cycle",  32'(load), 32'd0);
    end
    repeat (2) @(negedge clk);
  endtask

  // Counts from the cycle right after the consuming edge (n=0); the first
  // visible call here happens 3 cycles later because apply() waited.
  task automatic timeout_wait();
    int n;
    bit seen;
    n = 3;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (abort === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk("timeout_abort_seen", 32'(seen), 32'd1);
    chk("timeout_abort_cycle", 32'(n), 32'd16);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_pos",  32'(pos),  32'd0);
    chk("timeout_bcd",  32'(bcd),  32'hFFFFFF);
    chk("timeout_hour", 32'(hour), 32'(m_h));
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_mid_entry();
    int unsigned a0;
    a0 = abort_cnt;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_h = '0; m_m = '0; m_s = '0;
    chk("rst_hour",   32'(hour),   32'd0);
    chk("rst_minute", 32'(minute), 32'd0);
    chk("rst_second", 32'(second), 32'd0);
    chk("rst_load",   32'(load),   32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_pos",    32'(pos),    32'd0);
    chk("rst_bcd",    32'(bcd),    32'hFFFFFF);
    chk("rst_err",    32'(err),    32'd0);
    chk("rst_abort",  32'(abort),  32'd0);
    repeat (4) @(negedge clk);
    chk("rst_no_abort", abort_cnt, a0);
  endtask

  initial begin
    vec_t tab[$];
    int unsigned e0;

    reset = 1'b1; enter_n = 1'b1; cancel_n = 1'b1; digit = 4'd0;

    // session 1: invalid H1 in IDLE, then 15:30:45 with rejects along the way
    tab.push_back(mk(1, 4'h7, 1, 0, 0, 24'hFFFFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'hA, 1, 0, 0, 24'hFFFFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h1, 0, 0, 1, 24'h1FFFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h5, 0, 0, 2, 24'h15FFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h6, 1, 0, 2, 24'h15FFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h3, 0, 0, 3, 24'h153FFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'hF, 1, 0, 3, 24'h153FFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h0, 0, 0, 4, 24'h1530FF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h4, 0, 0, 5, 24'h15304F, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h5, 0, 0, 0, 24'h153045, 1, 15, 30, 45, 0));
    // cancel in IDLE is ignored; bcd keeps the full entry
    tab.push_back(mk(2, 4'h0, 0, 0, 0, 24'h153045, 0, 0, 0, 0, 0));
    // 1,2 then cancel: abort, outputs hold 15:30:45
    tab.push_back(mk(1, 4'h1, 0, 0, 1, 24'h1FFFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h2, 0, 0, 2, 24'h12FFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(2, 4'h0, 0, 1, 0, 24'hFFFFFF, 0, 0, 0, 0, 0));
    // 23:59:59 with H0=4 and S1=6 rejected
    tab.push_back(mk(1, 4'h3, 1, 0, 0, 24'hFFFFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h2, 0, 0, 1, 24'h2FFFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h4, 1, 0, 1, 24'h2FFFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h3, 0, 0, 2, 24'h23FFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h5, 0, 0, 3, 24'h235FFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h9, 0, 0, 4, 24'h2359FF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h6, 1, 0, 4, 24'h2359FF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h5, 0, 0, 5, 24'h23595F, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h9, 0, 0, 0, 24'h235959, 1, 23, 59, 59, 0));
    // H1=0 then idle until timeout
    tab.push_back(mk(1, 4'h0, 0, 0, 1, 24'h0FFFFF, 0, 0, 0, 0, 1));
    // 09:00:00
    tab.push_back(mk(1, 4'h0, 0, 0, 1, 24'h0FFFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h9, 0, 0, 2, 24'h09FFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h0, 0, 0, 3, 24'h090FFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h0, 0, 0, 4, 24'h0900FF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h0, 0, 0, 5, 24'h09000F, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h0, 0, 0, 0, 24'h090000, 1, 9, 0, 0, 0));
    // enter and cancel together in D3: abort only, digit discarded
    tab.push_back(mk(1, 4'h1, 0, 0, 1, 24'h1FFFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h2, 0, 0, 2, 24'h12FFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h3, 0, 0, 3, 24'h123FFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(3, 4'h4, 0, 1, 0, 24'hFFFFFF, 0, 0, 0, 0, 0));
    // reach D4 then reset
    tab.push_back(mk(1, 4'h1, 0, 0, 1, 24'h1FFFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h2, 0, 0, 2, 24'h12FFFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h3, 0, 0, 3, 24'h123FFF, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4'h4, 0, 0, 4, 24'h1234FF, 0, 0, 0, 0, 2));

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("init_hour",   32'(hour),   32'd0);
    chk("init_minute", 32'(minute), 32'd0);
    chk("init_second", 32'(second), 32'd0);
    chk("init_load",   32'(load),   32'd0);
    chk("init_busy",   32'(busy),   32'd0);
    chk("init_pos",    32'(pos),    32'd0);
    chk("init_bcd",    32'(bcd),    32'hFFFFFF);
    chk("init_err",    32'(err),    32'd0);
    chk("init_abort",  32'(abort),  32'd0);

    for (int i = 0; i < tab.size(); i++) begin
      apply(tab[i]);
      if (tab[i].hook == 1) timeout_wait();
      if (tab[i].hook == 2) reset_mid_entry();
    end

    // holding enter low yields one press (invalid digit in IDLE -> one err)
    e0 = err_cnt;
    @(negedge clk);
    digit = 4'h9;
    enter_n = 1'b0;
    repeat (100) @(negedge clk);
    enter_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("hold_single_press", err_cnt - e0, 32'd1);
    chk("hold_pos",  32'(pos),  32'd0);
    chk("hold_busy", 32'(busy), 32'd0);

    chk("loads_outstanding", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_entry.md
# time_entry

Digit-by-digit time entry controller for the wall-clock datapath. An operator types six BCD digits (H1 H0 M1 M0 S1 S0) on `digit` and confirms each with the `enter_n` key. The block validates each digit against 24-hour clock limits and echoes the entry for display. When the last digit is accepted, it presents binary hour/minute/second with a one-cycle `load` strobe, which the clock core uses to preset its counters. It is the writer side of the clock's time-set port, and the inverse of the clock's binary-to-BCD display path.

## Interface
- `TIMEOUT`, default 250_000_000: idle cycles (no key press) while busy before the entry is aborted; counter width 28 bits.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `enter_n` in 1: raw push-button, active-low; a press accepts `digit`.
- `cancel_n` in 1: raw push-button, active-low; a press aborts the entry.
- `digit` in 4: BCD digit candidate; static switch input, sampled when a press is detected.
- `hour` out 5: binary hour 0–23; holds the last loaded value.
- `minute` out 6: binary minute 0–59.
- `second` out 6: binary second 0–59.
- `load` out 1: one-cycle pulse; `hour`/`minute`/`second` are new and valid.
- `busy` out 1: high while an entry is in progress.
- `pos` out 3: index of the next digit expected, 0=H1 … 5=S0.
- `bcd` out 24: echo of the accepted digits, {H1,H0,M1,M0,S1,S0}; positions not yet entered read 4'hF (blank on the 7-seg decoder).
- `err` out 1: one-cycle pulse; a digit was rejected.
- `abort` out 1: one-cycle pulse; entry abandoned by cancel or timeout.

## Operation
- Key conditioning:
  - Each key passes through a 2-flop synchronizer, reset to 1.
  - A press is a 1→0 transition on the synchronized signal, one pulse per press.
  - Holding a key produces no repeat presses.
- States: IDLE, D0..D5 (D*n* awaits digit *n*), COMMIT.
- IDLE:
  - `busy`=0, `pos`=0.
  - An enter press is treated as the H1 attempt: if valid, store it and go to D1; if invalid, pulse `err` and stay in IDLE.
  - A cancel press in IDLE is ignored: no `abort`.
- D1..D5, on an enter press:
  - Valid digit: store it, advance.
  - Invalid digit: pulse `err`, stay in the same state; the stored digits are kept.
- Digit validity limits:
  - H1 ≤ 2.
  - H0 ≤ 9 if H1 < 2, ≤ 3 if H1 = 2.
  - M1 ≤ 5; M0 ≤ 9.
  - S1 ≤ 5; S0 ≤ 9.
  - Any value 10–15 is always invalid.
- Accepting S0 in D5 moves to COMMIT.
- COMMIT (one cycle):
  - hour = 10·H1+H0, minute = 10·M1+M0, second = 10·S1+S0.
  - Register these and assert `load`.
  - Return to IDLE with `bcd` held showing the full entry.
  - `bcd` returns to all-F at the next accepted H1.
- Cancel press in D0..D5, or timeout counter reaching `TIMEOUT`-1:
  - Pulse `abort`, go to IDLE, set `bcd` to all-F.
  - `hour`/`minute`/`second` are unchanged; no `load`.
- Timeout counter:
  - Runs only in D1..D5.
  - Clears on every detected enter press, accepted or rejected.
  - Clears on entry into D1.
- Enter and cancel presses detected in the same cycle: cancel wins, the digit is discarded.
- `hour`/`minute`/`second` change only in COMMIT.

## Timing
- Reset values:
  - state IDLE.
  - `hour`=0, `minute`=0, `second`=0.
  - `load`=0, `busy`=0, `pos`=0, `err`=0, `abort`=0.
  - `bcd`=24'hFFFFFF, timeout counter 0, synchronizer flops 1.
- Reset mid-entry: back to IDLE on the next edge; no `load`, no `abort`.
- Key fall to detected press: 2 clock cycles, plus 1 cycle for the edge-detect register.
- On the edge that consumes a press, `digit` is sampled and `pos`/`bcd`/state update. `err` is high in the following cycle.
- The S0 press edge enters COMMIT. `load` is high exactly in the next cycle, with the new `hour`/`minute`/`second` visible in that same cycle. `busy` drops in the cycle after `load`.
- Minimum spacing between accepted presses: 1 cycle. There is no dead time beyond key conditioning.

## Test plan
- Enter 1,5,3,0,4,5 after reset → one `load` pulse with hour=15, minute=30, second=45; `bcd`=24'h153045; `busy` returns to 0.
- Enter 2, then 4 (rejected, `err` pulse, `pos` stays 1), then 3,5,9,5,9 → hour=23, minute=59, second=59.
- Enter 1,2 then a cancel press → `abort` pulse, `bcd`=24'hFFFFFF, outputs still hold the previous values (15/30/45), no `load`.
- With `TIMEOUT`=16: enter 0 then wait 20 cycles → `abort` in cycle 16 after the press is consumed; state IDLE; a subsequent 0,9,0,0,0,0 entry loads 09:00:00.
- Assert enter and cancel falling edges together in D3 → `abort` only, no digit stored; `reset` asserted in D4 → IDLE, all outputs at reset values, no `load`.
- Enter H1=7 and digit=4'hA in IDLE → `err` each time, `busy`=0; holding `enter_n` low for 100 cycles yields a single press.
